// File: rtl/branch_update_scheduler_pkg.sv
// Shared types for the branch update scheduler: FSM state and update-queue entry.
package branch_update_scheduler_pkg;

  // Widest table index the entry struct can carry; the scheduler uses the low IDX_W bits.
  localparam int IDX_MAX_W = 32;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_t;

  typedef struct packed {
    logic [IDX_MAX_W-1:0] idx;
    logic                 taken;
  } upd_entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/branch_update_fifo.sv
// Update queue: power-of-two FIFO, push/pop legal together at any occupancy.
module update_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/branch_update_scheduler.sv
// Queues resolved-branch training updates for the predictor table and raises
// redirect/flush on mispredicts, ignoring wrong-path results while squashing.
module branch_update_scheduler
  import branch_update_scheduler_pkg::*;
#(
  parameter int IDX_W      = 6,
  parameter int QDEPTH     = 4,
  parameter int SQUASH_CYC = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [31:0]      ex_pc,
  input  logic             ex_taken,
  input  logic             ex_predicted_taken,
  input  logic [31:0]      ex_target,
  input  logic             lk_req,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_widx,
  output logic             tbl_wtaken,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             q_full,
  output logic [15:0]      mispredict_count,
  output logic [7:0]       drop_count
);
  localparam int SQ_W = (SQUASH_CYC > 1) ? $clog2(SQUASH_CYC) : 1;
  localparam int EW   = $bits(upd_entry_t);

  state_t          state, state_nxt;
  logic [SQ_W-1:0] sq_cnt;
  logic            accept, mispredict, q_pop, q_empty, drop;
  upd_entry_t      push_ent, head_ent;
  logic            unused_head_idx;

  update_fifo #(.DEPTH(QDEPTH), .WIDTH(EW)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (accept),
    .wdata (push_ent),
    .pop   (q_pop),
    .rdata (head_ent),
    .full  (q_full),
    .empty (q_empty)
  );

  assign unused_head_idx = ^head_ent.idx;

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (mispredict) state_nxt = SQUASH;
      SQUASH:  if (sq_cnt == '0) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    accept       = ex_valid & ex_is_branch & (state == RUN);
    mispredict   = accept & (ex_taken != ex_predicted_taken);
    push_ent     = '0;
    push_ent.idx[IDX_W-1:0] = ex_pc[IDX_W-1:0];
    push_ent.taken = ex_taken;
    // Decode lookups own the table port; training only uses idle cycles.
    q_pop        = ~lk_req & ~q_empty;
    tbl_we       = q_pop;
    tbl_widx     = q_pop ? head_ent.idx[IDX_W-1:0] : '0;
    tbl_wtaken   = q_pop & head_ent.taken;
    drop         = accept & q_full & ~q_pop;
  end

  // Loaded on entry so SQUASH spans exactly SQUASH_CYC cycles after that edge.
  always_ff @(posedge clock) begin
    if (reset)                           sq_cnt <= '0;
    else if (state == RUN && mispredict) sq_cnt <= SQ_W'(SQUASH_CYC - 1);
    else if (state == SQUASH && sq_cnt != '0) sq_cnt <= sq_cnt - SQ_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      redirect_valid   <= 1'b0;
      flush            <= 1'b0;
      redirect_pc      <= '0;
      mispredict_count <= '0;
      drop_count       <= '0;
    end else begin
      redirect_valid <= mispredict;
      flush          <= mispredict;
      redirect_pc    <= mispredict ? (ex_taken ? ex_target : ex_pc + 32'd1) : '0;
      if (mispredict) mispredict_count <= sat_inc16(mispredict_count);
      if (drop)       drop_count       <= sat_inc8(drop_count);
    end
  end

endmodule

// File: tb/tb_branch_update_scheduler.sv
// Directed bench with a write-order scoreboard for branch_update_scheduler.
module tb_branch_update_scheduler;
  localparam int IDX_W  = 6;
  localparam int QDEPTH = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             ex_valid = 1'b0, ex_is_branch = 1'b0, ex_taken = 1'b0;
  logic             ex_predicted_taken = 1'b0, lk_req = 1'b0;
  logic [31:0]      ex_pc = '0, ex_target = '0;
  logic             tbl_we, tbl_wtaken, redirect_valid, flush, q_full;
  logic [IDX_W-1:0] tbl_widx;
  logic [31:0]      redirect_pc;
  logic [15:0]      mispredict_count;
  logic [7:0]       drop_count;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   exp_mis  = 0;
  int   exp_drop = 0;

  branch_update_scheduler #(.IDX_W(IDX_W), .QDEPTH(QDEPTH), .SQUASH_CYC(2)) dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_predicted_taken(ex_predicted_taken),
    .ex_target(ex_target), .lk_req(lk_req), .tbl_we(tbl_we), .tbl_widx(tbl_widx),
    .tbl_wtaken(tbl_wtaken), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .q_full(q_full), .mispredict_count(mispredict_count),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs; acc marks a resolution the design should accept.
  task automatic drive(input logic br, input logic [31:0] pc, input logic tk, input logic pt,
                       input logic [31:0] tgt, input logic lk, input logic acc);
    exp_t e;
    ex_valid = br; ex_is_branch = br; ex_pc = pc; ex_taken = tk;
    ex_predicted_taken = pt; ex_target = tgt; lk_req = lk;
    if (acc) begin
      e.idx = pc[IDX_W-1:0];
      e.taken = tk;
      if (sb.size() < QDEPTH || (!lk && sb.size() > 0)) sb.push_back(e);
      else exp_drop++;
      if (tk != pt) exp_mis++;
    end
  endtask

  task automatic idle(input logic lk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, lk, 1'b0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_tbl_we"}, 32'(tbl_we), 32'h0);
    chk({pfx, "_tbl_widx"}, 32'(tbl_widx), 32'h0);
    chk({pfx, "_tbl_wtaken"}, 32'(tbl_wtaken), 32'h0);
    chk({pfx, "_redirect_valid"}, 32'(redirect_valid), 32'h0);
    chk({pfx, "_redirect_pc"}, redirect_pc, 32'h0);
    chk({pfx, "_flush"}, 32'(flush), 32'h0);
    chk({pfx, "_q_full"}, 32'(q_full), 32'h0);
    chk({pfx, "_mis_cnt"}, 32'(mispredict_count), 32'h0);
    chk({pfx, "_drop_cnt"}, 32'(drop_count), 32'h0);
  endtask

  // Scoreboard: every table write must match the oldest outstanding update.
  always @(negedge clock) begin
    if (!reset && tbl_we) begin
      chk("sb_write_expected", 32'(sb.size() > 0), 32'h1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_widx", 32'(tbl_widx), 32'(e.idx));
        chk("sb_wtaken", 32'(tbl_wtaken), 32'(e.taken));
      end
    end
  end

  initial begin
    idle(1'b0);
    reset = 1'b1;
    tick(); tick();
    chk_zero("reset");
    reset = 1'b0;

    // Correct prediction trains the table the next cycle.
    drive(1'b1, 32'h45, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1);
    tick();
    idle(1'b0);
    #1;
    chk("basic_tbl_we", 32'(tbl_we), 32'h1);
    chk("basic_widx", 32'(tbl_widx), 32'h05);
    chk("basic_wtaken", 32'(tbl_wtaken), 32'h1);
    chk("basic_flush", 32'(flush), 32'h0);
    tick();

    // Not-taken mispredict, then a wrong-path branch in the squash window.
    drive(1'b1, 32'h10, 1'b0, 1'b1, 32'h999, 1'b0, 1'b1);
    tick();
    chk("mp_flush", 32'(flush), 32'h1);
    chk("mp_redirect_valid", 32'(redirect_valid), 32'h1);
    chk("mp_redirect_pc", redirect_pc, 32'h11);
    chk("mp_count", 32'(mispredict_count), 32'(exp_mis));
    drive(1'b1, 32'h20, 1'b1, 1'b0, 32'h50, 1'b0, 1'b0);
    tick();
    chk("sq_flush", 32'(flush), 32'h0);
    chk("sq_redirect_valid", 32'(redirect_valid), 32'h0);
    chk("sq_count", 32'(mispredict_count), 32'(exp_mis));
    // Mispredict in the last squash cycle is ignored.
    drive(1'b1, 32'h21, 1'b1, 1'b0, 32'h77, 1'b0, 1'b0);
    tick();
    chk("sq_last_flush", 32'(flush), 32'h0);
    chk("sq_last_count", 32'(mispredict_count), 32'(exp_mis));
    // First RUN cycle accepts again; taken mispredict redirects to target.
    drive(1'b1, 32'h22, 1'b1, 1'b0, 32'h300, 1'b0, 1'b1);
    tick();
    chk("run_again_flush", 32'(flush), 32'h1);
    chk("run_again_pc", redirect_pc, 32'h300);
    chk("run_again_count", 32'(mispredict_count), 32'(exp_mis));
    idle(1'b0);
    tick(); tick(); tick();

    // Lookups hold the port: queue fills, fifth update drops.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h31 + 32'(i), i[0], i[0], 32'h0, 1'b1, 1'b1);
      tick();
      chk("lk_tbl_we", 32'(tbl_we), 32'h0);
      if (i == 3) chk("lk_q_full", 32'(q_full), 32'h1);
    end
    chk("lk_drop_count", 32'(drop_count), 32'(exp_drop));
    idle(1'b1);
    tick();
    chk("lk_hold_tbl_we", 32'(tbl_we), 32'h0);
    chk("lk_hold_q_full", 32'(q_full), 32'h1);

    // Full queue, port free: push and pop together.
    drive(1'b1, 32'h3A, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1);
    #1;
    chk("full_pp_tbl_we", 32'(tbl_we), 32'h1);
    tick();
    chk("full_pp_q_full", 32'(q_full), 32'h1);
    chk("full_pp_drop", 32'(drop_count), 32'(exp_drop));
    idle(1'b0);
    tick();
    chk("drain_q_full", 32'(q_full), 32'h0);
    tick(); tick(); tick();
    chk("drain_tbl_we", 32'(tbl_we), 32'h0);
    chk("drain_sb_empty", 32'(sb.size()), 32'h0);

    // Fall-through pc wraps.
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h5, 1'b0, 1'b1);
    tick();
    chk("wrap_redirect_valid", 32'(redirect_valid), 32'h1);
    chk("wrap_redirect_pc", redirect_pc, 32'h0);
    chk("wrap_count", 32'(mispredict_count), 32'(exp_mis));
    idle(1'b0);
    tick(); tick(); tick();

    // Reset during SQUASH with three queued entries.
    drive(1'b1, 32'h01, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'h02, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'h03, 1'b1, 1'b0, 32'h40, 1'b1, 1'b1);
    tick();
    chk("pre_rst_flush", 32'(flush), 32'h1);
    chk("pre_rst_q_full", 32'(q_full), 32'h0);
    reset = 1'b1;
    idle(1'b0);
    tick();
    sb.delete();
    exp_mis = 0;
    exp_drop = 0;
    chk_zero("mid_rst");
    tick();
    chk_zero("held_rst");
    reset = 1'b0;
    drive(1'b1, 32'h07, 1'b1, 1'b0, 32'h1234, 1'b0, 1'b1);
    tick();
    chk("post_rst_flush", 32'(flush), 32'h1);
    chk("post_rst_redirect_valid", 32'(redirect_valid), 32'h1);
    chk("post_rst_pc", redirect_pc, 32'h1234);
    chk("post_rst_count", 32'(mispredict_count), 32'(exp_mis));
    idle(1'b0);
    tick(); tick(); tick();
    chk("final_sb_empty", 32'(sb.size()), 32'h0);
    chk("final_tbl_we", 32'(tbl_we), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
